hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard and forwarding responder paired with the ID-stage decode controller.
- Tracks in-flight destination registers of the EX, MEM and WB stages in an internal shadow pipeline.
- Produces sel_cancel (1 = pass decoded controls, 0 = insert bubble), PC/IF-ID write enables, IF-ID flush gating, and EX-stage forwarding selects.

Parameters:
REG_AW, 5, register address width
MAX_STALL, 2, maximum legal consecutive stall cycles; exceeding it sets stall_err

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
id_opcode  in  6  opcode of instruction in ID
id_rs  in  REG_AW  rs field in ID
id_rt  in  REG_AW  rt field in ID
id_wreg  in  REG_AW  destination after regDst mux
id_regWrite  in  1  decoded regWrite (pre-cancel)
id_memRead  in  1  decoded memRead (pre-cancel)
clear_IFID  in  1  flush request from controller
sel_cancel  out  1  1 = pass ID controls, 0 = bubble
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  gated IF/ID clear
fwdA  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwdB  out  2  EX operand B select, same encoding
stall_err  out  1  sticky stall-overrun flag
stall_cycles  out  32  stall-cycle count (optional feature)

Behaviour:
- Operand use decode:
  - R-type (000000), sw (101011), beq (000100), bne (000101): use rs and rt.
  - addi (001000), andi (001100), lw (100011): use rs only.
  - j (000010) and any other opcode: use neither.
- Shadow stages EX/MEM/WB each hold {valid, wr, ld, wreg, rs, rt}. Every posedge, the contents advance EX→MEM→WB.
- EX is loaded from ID when not stalled: valid=1, wr=id_regWrite, ld=id_memRead, plus fields. When stalled, EX gets a bubble (valid=0).
- Hit(S,r): S.valid & S.wr & S.wreg!=0 & S.wreg==r & r is used. Register 0 never hits.
- Stall when any of the following hold:
  - load-use: EX.ld and Hit(EX, rs or rt).
  - ID branch (beq/bne) with Hit(EX) on any writer.
  - ID branch with Hit(MEM) where MEM.ld.
- Stall lengths: lw→dependent ALU op = 1 cycle; ALU→branch = 1; lw→branch = 2.
- Stall outputs: sel_cancel=0, pc_write=0, ifid_write=0 (combinational from shadow state and ID inputs, same cycle).
- ifid_flush = clear_IFID & ~stall. The stall has priority because the branch compare is not yet valid.
- Forwarding, evaluated on EX.rs (fwdA) and EX.rt (fwdB):
  - MEM hit → 10.
  - else WB hit → 01.
  - else 00.
  - MEM has priority over WB when both hit.
- Stall counter: increments on each consecutive stall cycle and clears on a non-stall cycle. If it would exceed MAX_STALL, stall_err sets and remains set until reset.
- Reset (rst low at posedge):
  - All shadow valid=0, counters 0, stall_err=0.
  - While rst is low, outputs are forced: sel_cancel=1, pc_write=1, ifid_write=1, ifid_flush=0, fwdA=fwdB=00.
- Reset mid-stall clears the stall. The first cycle after reset never stalls, since the shadow is empty.

Optional Feature:
- HAZARD_STALL_COUNT_EN defined: stall_cycles is a 32-bit counter of total stall cycles. It saturates at all-ones, and sync reset sets it to 0.
- Not defined: stall_cycles is tied to 0 and no counter flops are built.

Test Plan:
- lw $2,0($1) then add $3,$2,$4 → 1 cycle with sel_cancel=0, pc_write=0, ifid_write=0; next cycle add is in EX with fwdA=01.
- add $2,$1,$1 then sub $5,$2,$2 → no stall; sub in EX has fwdA=10 and fwdB=10.
- lw $5,4($0) then beq $5,$6 → exactly 2 stall cycles; clear_IFID=1 during the stall gives ifid_flush=0; after the stall, ifid_flush follows clear_IFID.
- addi $0,$1,7 then add $3,$0,$0 → no stall, fwdA=fwdB=00.
- Writers to $7 in both MEM and WB with EX.rs=$7 → fwdA=10.
- Assert rst=0 during a lw stall → next edge gives sel_cancel=1, stall_err=0, stall_cycles=0 (with HAZARD_STALL_COUNT_EN); three consecutive stalls with MAX_STALL=2 → stall_err=1.

Source files
------------

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit : ID-stage hazard detection and EX-stage forwarding responder.
//   Optional total stall-cycle counter enabled by HAZARD_STALL_COUNT_EN.
// Revision: 1.0
// ============================================================================
module hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int MAX_STALL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              clear_IFID,
  output logic              sel_cancel,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              stall_err,
  output logic [31:0]       stall_cycles
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CW = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0] STALL_LIM = MAX_STALL[CW-1:0];

  logic id_use_rs, id_use_rt, id_branch;

  always_comb begin
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_branch = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_SW: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
        id_branch = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_LW: id_use_rs = 1'b1;
      default: ;
    endcase
  end

  // Shadow pipeline; later stages keep only the fields still consulted.
  logic              ex_valid, ex_wr, ex_ld, ex_use_rs, ex_use_rt;
  logic [REG_AW-1:0] ex_wreg, ex_rs, ex_rt;
  logic              mem_valid, mem_wr, mem_ld;
  logic [REG_AW-1:0] mem_wreg;
  logic              wb_valid, wb_wr;
  logic [REG_AW-1:0] wb_wreg;

  function automatic logic hit(input logic v, input logic wr,
                               input logic [REG_AW-1:0] wreg,
                               input logic [REG_AW-1:0] r,
                               input logic used);
    return v & wr & (wreg != '0) & (wreg == r) & used;
  endfunction

  logic ex_hit_any, mem_hit_any, stall;

  assign ex_hit_any  = hit(ex_valid, ex_wr, ex_wreg, id_rs, id_use_rs)
                     | hit(ex_valid, ex_wr, ex_wreg, id_rt, id_use_rt);
  assign mem_hit_any = hit(mem_valid, mem_wr, mem_wreg, id_rs, id_use_rs)
                     | hit(mem_valid, mem_wr, mem_wreg, id_rt, id_use_rt);

  assign stall = rst & ((ex_ld & ex_hit_any)
                      | (id_branch & ex_hit_any)
                      | (id_branch & mem_ld & mem_hit_any));

  always_comb begin
    sel_cancel = ~stall;
    pc_write   = ~stall;
    ifid_write = ~stall;
    ifid_flush = clear_IFID & ~stall;
    fwdA       = 2'b00;
    fwdB       = 2'b00;
    if (hit(mem_valid, mem_wr, mem_wreg, ex_rs, ex_use_rs))
      fwdA = 2'b10;
    else if (hit(wb_valid, wb_wr, wb_wreg, ex_rs, ex_use_rs))
      fwdA = 2'b01;
    if (hit(mem_valid, mem_wr, mem_wreg, ex_rt, ex_use_rt))
      fwdB = 2'b10;
    else if (hit(wb_valid, wb_wr, wb_wreg, ex_rt, ex_use_rt))
      fwdB = 2'b01;
    if (!rst) begin
      sel_cancel = 1'b1;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      fwdA       = 2'b00;
      fwdB       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_use_rs <= 1'b0;
      ex_use_rt <= 1'b0;
      ex_wreg   <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_ld    <= 1'b0;
      mem_wreg  <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_wreg   <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_wr     <= mem_wr;
      wb_wreg   <= mem_wreg;
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_ld    <= ex_ld;
      mem_wreg  <= ex_wreg;
      ex_valid  <= ~stall;
      ex_wr     <= ~stall & id_regWrite;
      ex_ld     <= ~stall & id_memRead;
      ex_use_rs <= ~stall & id_use_rs;
      ex_use_rt <= ~stall & id_use_rt;
      ex_wreg   <= id_wreg;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
    end
  end

  // Consecutive-stall run length; saturates one past the limit.
  logic [CW-1:0] stall_run;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_run <= '0;
      stall_err <= 1'b0;
    end else if (stall) begin
      if (stall_run <= STALL_LIM)
        stall_run <= stall_run + 1'b1;
      if (stall_run >= STALL_LIM)
        stall_err <= 1'b1;
    end else begin
      stall_run <= '0;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_total;

  always_ff @(posedge clk) begin
    if (!rst)
      stall_total <= 32'd0;
    else if (stall && (stall_total != 32'hFFFF_FFFF))
      stall_total <= stall_total + 32'd1;
  end

  assign stall_cycles = stall_total;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// Scoreboard bench for hazard_unit: a reference model tracking in-flight
// instructions predicts each cycle's outputs; a monitor compares them.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wreg = '0;
  logic        id_regWrite = 1'b0, id_memRead = 1'b0, clear_IFID = 1'b0;

  logic        sel_cancel, pc_write, ifid_write, ifid_flush, stall_err;
  logic [1:0]  fwdA, fwdB;
  logic [31:0] stall_cycles;
  logic        sel_cancel1, pc_write1, ifid_write1, ifid_flush1, stall_err1;
  logic [1:0]  fwdA1, fwdB1;
  logic [31:0] stall_cycles1;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .MAX_STALL(2)) u_dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_wreg(id_wreg), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .clear_IFID(clear_IFID), .sel_cancel(sel_cancel), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .fwdA(fwdA), .fwdB(fwdB),
    .stall_err(stall_err), .stall_cycles(stall_cycles));

  // Tighter limit so that the two-cycle lw->branch stall trips the error flag.
  hazard_unit #(.REG_AW(5), .MAX_STALL(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_wreg(id_wreg), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .clear_IFID(clear_IFID), .sel_cancel(sel_cancel1), .pc_write(pc_write1),
    .ifid_write(ifid_write1), .ifid_flush(ifid_flush1), .fwdA(fwdA1), .fwdB(fwdB1),
    .stall_err(stall_err1), .stall_cycles(stall_cycles1));

  typedef struct {
    bit v, wr, ld, ur, ut;
    int wreg, rs, rt;
  } instr_t;

  typedef struct {
    bit sel_cancel, pc_write, ifid_write, ifid_flush, err2, err1;
    bit [1:0] fa, fb;
    longint cycles;
  } exp_t;

  instr_t inflight[3];   // index = age: 0 in EX, 1 in MEM, 2 in WB
  exp_t   sb[$];
  int     consec;
  bit     err2, err1, last_stall;
  longint total;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic bit uses_rs(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23};
  endfunction

  function automatic bit uses_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h2B, 6'h04, 6'h05};
  endfunction

  function automatic bit writes(input instr_t s, input int r, input bit used);
    return used && s.v && s.wr && s.wreg != 0 && s.wreg == r;
  endfunction

  function automatic bit model_stall();
    bit ur, ut, br, ex_hit, mem_hit;
    ur = uses_rs(id_opcode);
    ut = uses_rt(id_opcode);
    br = (id_opcode == 6'h04) || (id_opcode == 6'h05);
    ex_hit  = writes(inflight[0], id_rs, ur) || writes(inflight[0], id_rt, ut);
    mem_hit = writes(inflight[1], id_rs, ur) || writes(inflight[1], id_rt, ut);
    if (!rst) return 1'b0;
    return (inflight[0].ld && ex_hit) || (br && ex_hit) || (br && inflight[1].ld && mem_hit);
  endfunction

  function automatic bit [1:0] fwd_sel(input int r, input bit used);
    if (writes(inflight[1], r, used)) return 2'b10;
    if (writes(inflight[2], r, used)) return 2'b01;
    return 2'b00;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    instr_t empty;
    bit st;
    empty = '{default: 0};
    if (!rst) begin
      inflight = '{empty, empty, empty};
      consec = 0; err2 = 0; err1 = 0; total = 0;
    end else begin
      st = model_stall();
      inflight[2] = inflight[1];
      inflight[1] = inflight[0];
      if (st) inflight[0] = empty;
      else begin
        inflight[0] = '{v: 1, wr: id_regWrite, ld: id_memRead,
                        ur: uses_rs(id_opcode), ut: uses_rt(id_opcode),
                        wreg: id_wreg, rs: id_rs, rt: id_rt};
      end
      if (st) begin
        consec++;
        if (consec > 2) err2 = 1;
        if (consec > 1) err1 = 1;
        if (total != 64'hFFFF_FFFF) total++;
      end else consec = 0;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    bit st;
    st = model_stall();
    last_stall = st;
    e.sel_cancel = !st;
    e.pc_write   = !st;
    e.ifid_write = !st;
    e.ifid_flush = rst && clear_IFID && !st;
    e.fa = rst ? fwd_sel(inflight[0].rs, inflight[0].ur) : 2'b00;
    e.fb = rst ? fwd_sel(inflight[0].rt, inflight[0].ut) : 2'b00;
    e.err2 = err2;
    e.err1 = err1;
`ifdef HAZARD_STALL_COUNT_EN
    e.cycles = total;
`else
    e.cycles = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic one_cycle(input bit r, input logic [5:0] op, input int rs, input int rt,
                           input int wreg, input bit rw, input bit mr, input bit clr);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; id_opcode = op; id_rs = 5'(rs); id_rt = 5'(rt); id_wreg = 5'(wreg);
    id_regWrite = rw; id_memRead = mr; clear_IFID = clr;
    push_expect();
  endtask

  // Present one instruction in ID and hold it for as long as it is stalled.
  task automatic send(input logic [5:0] op, input int rs, input int rt,
                      input int wreg, input bit rw, input bit mr, input bit clr);
    int guard = 0;
    one_cycle(1'b1, op, rs, rt, wreg, rw, mr, clr);
    while (last_stall && guard < 8) begin
      one_cycle(1'b1, op, rs, rt, wreg, rw, mr, clr);
      guard++;
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) send(6'h00, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sel_cancel", 32'(sel_cancel), 32'(e.sel_cancel));
        chk("pc_write",   32'(pc_write),   32'(e.pc_write));
        chk("ifid_write", 32'(ifid_write), 32'(e.ifid_write));
        chk("ifid_flush", 32'(ifid_flush), 32'(e.ifid_flush));
        chk("fwdA",       32'(fwdA),       32'(e.fa));
        chk("fwdB",       32'(fwdB),       32'(e.fb));
        chk("stall_err",  32'(stall_err),  32'(e.err2));
        chk("stall_err_max1", 32'(stall_err1), 32'(e.err1));
        chk("stall_cycles", stall_cycles, e.cycles[31:0]);
      end
    end
  end

  initial begin : stimulus
    logic [5:0] ops [9];
    int wait_cnt;
    ops = '{6'h00, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h23, 6'h02, 6'h3F};
    inflight = '{default: '{default: 0}};
    consec = 0; err2 = 0; err1 = 0; total = 0;

    one_cycle(1'b0, 6'h00, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    one_cycle(1'b0, 6'h00, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // lw $2,0($1) ; add $3,$2,$4
    send(6'h23, 1, 2, 2, 1'b1, 1'b1, 1'b0);
    send(6'h00, 2, 4, 3, 1'b1, 1'b0, 1'b0);
    nops(3);
    // add $2,$1,$1 ; sub $5,$2,$2
    send(6'h00, 1, 1, 2, 1'b1, 1'b0, 1'b0);
    send(6'h00, 2, 2, 5, 1'b1, 1'b0, 1'b0);
    nops(3);
    // lw $5,4($0) ; beq $5,$6 with flush requested
    send(6'h23, 0, 5, 5, 1'b1, 1'b1, 1'b0);
    send(6'h04, 5, 6, 0, 1'b0, 1'b0, 1'b1);
    send(6'h00, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    nops(3);
    // addi $0,$1,7 ; add $3,$0,$0
    send(6'h08, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    send(6'h00, 0, 0, 3, 1'b1, 1'b0, 1'b0);
    nops(3);
    // two writers of $7, then a reader of $7
    send(6'h00, 1, 1, 7, 1'b1, 1'b0, 1'b0);
    send(6'h00, 2, 2, 7, 1'b1, 1'b0, 1'b0);
    send(6'h00, 7, 1, 8, 1'b1, 1'b0, 1'b0);
    nops(3);
    // reset in the middle of a load-use stall
    send(6'h23, 1, 2, 2, 1'b1, 1'b1, 1'b0);
    one_cycle(1'b1, 6'h00, 2, 4, 3, 1'b1, 1'b0, 1'b0);
    one_cycle(1'b0, 6'h00, 2, 4, 3, 1'b1, 1'b0, 1'b1);
    one_cycle(1'b1, 6'h00, 2, 4, 3, 1'b1, 1'b0, 1'b0);
    nops(3);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 39) == 0)
        one_cycle(1'b0, op, 0, 0, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      else
        send(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             (op == 6'h23) ? 1'b1 : 1'($urandom_range(0, 1)),
             (op == 6'h23) ? 1'b1 : 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)));
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
